// File: rtl/secret_result_sink.sv
`default_nettype none
// ============================================================================
// Module      : secret_result_sink
// Description : Consumer of the per-cycle (cycle value, task result) stream.
//               Samples are buffered in a small FIFO. Every sample popped by
//               the downstream reader is checked against two rules:
//                 - offset rule   : (res - cyc) mod 2^WIDTH == RES_OFS
//                 - sequence rule : cyc == previous cyc + STEP (mod 2^WIDTH)
//               Sticky done/error flags report the outcome to the test top.
//
// Ports       : clk        clock
//               rst        synchronous reset, active-high
//               in_valid   upstream sample present
//               in_cyc     upstream cycle value       [WIDTH]
//               in_res     upstream task result       [WIDTH]
//               in_ready   FIFO can accept a sample (= !full)
//               out_valid  head sample available (= !empty)
//               out_cyc    head cycle value, 0 when empty [WIDTH]
//               out_ready  downstream accepts head
//               done       sticky, END_VAL sample drained with no error
//               error      sticky, a sequence or offset rule was violated
//               err_cnt    violation count [8]
//
// Options     : SECRET_RESULT_SINK_STATS_EN
//               Defined   : violations are counted (saturating at 255) and
//                           checking continues in RUN; END_VAL completes
//                           only when no violation has been seen.
//               Undefined : err_cnt is constant 0, first violation -> ERR.
//
// Revision    : 1.0 - initial release
// ============================================================================
module secret_result_sink #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 4,
    parameter int STEP    = 1,
    parameter int RES_OFS = 1,
    parameter int END_VAL = 90
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_cyc,
    input  logic [WIDTH-1:0] in_res,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_cyc,
    input  logic             out_ready,
    output logic             done,
    output logic             error,
    output logic [7:0]       err_cnt
);

    localparam int               c_addr_w  = $clog2(DEPTH);
    localparam logic [WIDTH-1:0] c_step    = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] c_res_ofs = WIDTH'(RES_OFS);
    localparam logic [WIDTH-1:0] c_end_val = WIDTH'(END_VAL);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // FIFO storage: each entry holds {res, cyc}
    // ------------------------------------------------------------------
    logic [2*WIDTH-1:0] r_mem [DEPTH];
    logic [c_addr_w:0]  r_wr_ptr;
    logic [c_addr_w:0]  r_rd_ptr;

    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic [2*WIDTH-1:0] w_head;
    logic [WIDTH-1:0]   w_head_cyc;
    logic [WIDTH-1:0]   w_head_res;

    // Pointers carry one extra wrap bit: equal low bits with differing
    // wrap bits means the write side has lapped the read side.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_addr_w] != r_rd_ptr[c_addr_w]) &&
                     (r_wr_ptr[c_addr_w-1:0] == r_rd_ptr[c_addr_w-1:0]);

    assign in_ready  = !w_full;
    assign out_valid = !w_empty;
    assign w_push    = in_valid && !w_full;
    assign w_pop     = !w_empty && out_ready;

    assign w_head     = r_mem[r_rd_ptr[c_addr_w-1:0]];
    assign w_head_cyc = w_head[WIDTH-1:0];
    assign w_head_res = w_head[2*WIDTH-1:WIDTH];

    // Storage is not reset, so the stale head is masked while empty.
    assign out_cyc = w_empty ? '0 : w_head_cyc;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_addr_w-1:0]] <= {in_res, in_cyc};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Rule checks on the sample being popped this cycle
    // ------------------------------------------------------------------
    state_t           r_state;
    logic             r_done;
    logic             r_error;
    logic             r_have_prev;
    logic [WIDTH-1:0] r_prev;

    logic w_checking;
    logic w_ofs_bad;
    logic w_seq_bad;
    logic w_viol;
    logic w_is_end;

    assign w_checking = (r_state == IDLE) || (r_state == RUN);
    assign w_ofs_bad  = ((w_head_res - w_head_cyc) != c_res_ofs);
    // Without a previous sample (first pop after reset) only the offset
    // rule applies.
    assign w_seq_bad  = r_have_prev && (w_head_cyc != (r_prev + c_step));
    assign w_viol     = w_ofs_bad || w_seq_bad;
    assign w_is_end   = (w_head_cyc == c_end_val);

`ifdef SECRET_RESULT_SINK_STATS_EN
    logic [7:0] r_err_cnt;
    assign err_cnt = r_err_cnt;
`else
    assign err_cnt = 8'd0;
`endif

    assign done  = r_done;
    assign error = r_error;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_have_prev <= 1'b0;
            r_prev      <= '0;
`ifdef SECRET_RESULT_SINK_STATS_EN
            r_err_cnt   <= 8'd0;
`endif
        end else begin
            if (w_pop) begin
                r_prev      <= w_head_cyc;
                r_have_prev <= 1'b1;
            end
            // DONE and ERR are absorbing: pops still drain the FIFO but
            // no longer affect the state or the flags.
            if (w_pop && w_checking) begin
`ifdef SECRET_RESULT_SINK_STATS_EN
                if (w_viol) begin
                    r_error <= 1'b1;
                    if (r_err_cnt != 8'hFF) begin
                        r_err_cnt <= r_err_cnt + 8'd1;
                    end
                end
                if (w_is_end) begin
                    if (w_viol || (r_err_cnt != 8'd0)) begin
                        r_state <= ERR;
                    end else begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end
                end else begin
                    r_state <= RUN;
                end
`else
                if (w_viol) begin
                    r_state <= ERR;
                    r_error <= 1'b1;
                end else if (w_is_end) begin
                    r_state <= DONE;
                    r_done  <= 1'b1;
                end else begin
                    r_state <= RUN;
                end
`endif
            end
        end
    end

endmodule
`default_nettype wire
